// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-master, one-slave arbiter for the SRAM-like bus
// Shares one slave between inst and data masters with exactly one transaction in flight.
module sram_like_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [31:0] s_addr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state_q;
  logic   grant_q;
  logic   grant_d;
  logic   last_grant_q;

  logic        in_addr;
  logic        in_data;
  logic        sel_req;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [3:0]  sel_wstrb;
  logic [31:0] sel_wdata;
  logic        fwd_data_ok;

  // Grant is 1 for the data master; a tie alternates unless data has fixed priority.
  always_comb begin
    grant_d = data_req;
    if (inst_req && data_req) begin
      grant_d = (FIXED_PRIO != 0) ? 1'b1 : ~last_grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_req || data_req) begin
            grant_q <= grant_d;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s_addr_ok) begin
            last_grant_q <= grant_q;
            state_q      <= DATA;
          end
        end
        DATA: begin
          if (s_data_ok) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_addr = (state_q == ADDR);
  assign in_data = (state_q == DATA);

  always_comb begin
    if (grant_q) begin
      sel_req   = data_req;
      sel_wr    = data_wr;
      sel_size  = data_size;
      sel_addr  = data_addr;
      sel_wstrb = data_wstrb;
      sel_wdata = data_wdata;
    end else begin
      sel_req   = inst_req;
      sel_wr    = inst_wr;
      sel_size  = inst_size;
      sel_addr  = inst_addr;
      sel_wstrb = inst_wstrb;
      sel_wdata = inst_wdata;
    end
  end

  // Slave-side fields are forced to zero outside ADDR so the bus is quiet when idle.
  assign s_req   = in_addr & sel_req;
  assign s_wr    = in_addr & sel_wr;
  assign s_size  = in_addr ? sel_size  : 2'b00;
  assign s_addr  = in_addr ? sel_addr  : 32'h0;
  assign s_wstrb = in_addr ? sel_wstrb : 4'h0;
  assign s_wdata = in_addr ? sel_wdata : 32'h0;

  assign inst_addr_ok = in_addr & ~grant_q & s_addr_ok;
  assign data_addr_ok = in_addr &  grant_q & s_addr_ok;

  assign fwd_data_ok  = in_data & s_data_ok;
  assign inst_data_ok = fwd_data_ok & ~grant_q;
  assign data_data_ok = fwd_data_ok &  grant_q;
  assign inst_rdata   = inst_data_ok ? s_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? s_rdata : 32'h0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
// Round-robin and fixed-priority instances share stimulus and a transaction-level model.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        s_addr_ok, s_data_ok;
  logic [31:0] s_rdata;

  logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        r_s_req, r_s_wr;
  logic [1:0]  r_s_size;
  logic [31:0] r_s_addr, r_s_wdata;
  logic [3:0]  r_s_wstrb;

  logic        f_inst_addr_ok, f_inst_data_ok, f_data_addr_ok, f_data_data_ok;
  logic [31:0] f_inst_rdata, f_data_rdata;
  logic        f_s_req, f_s_wr;
  logic [1:0]  f_s_size;
  logic [31:0] f_s_addr, f_s_wdata;
  logic [3:0]  f_s_wstrb;

  sram_like_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(r_inst_addr_ok), .inst_data_ok(r_inst_data_ok), .inst_rdata(r_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(r_data_addr_ok), .data_data_ok(r_data_data_ok), .data_rdata(r_data_rdata),
    .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_addr(r_s_addr),
    .s_wstrb(r_s_wstrb), .s_wdata(r_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  sram_like_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(f_inst_addr_ok), .inst_data_ok(f_inst_data_ok), .inst_rdata(f_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(f_data_addr_ok), .data_data_ok(f_data_data_ok), .data_rdata(f_data_rdata),
    .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_addr(f_s_addr),
    .s_wstrb(f_s_wstrb), .s_wdata(f_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata)
  );

  logic [139:0] r_obs, f_obs;
  assign r_obs = {r_inst_addr_ok, r_inst_data_ok, r_inst_rdata, r_data_addr_ok, r_data_data_ok,
                  r_data_rdata, r_s_req, r_s_wr, r_s_size, r_s_addr, r_s_wstrb, r_s_wdata};
  assign f_obs = {f_inst_addr_ok, f_inst_data_ok, f_inst_rdata, f_data_addr_ok, f_data_data_ok,
                  f_data_rdata, f_s_req, f_s_wr, f_s_size, f_s_addr, f_s_wstrb, f_s_wdata};

  int checks = 0;
  int errors = 0;

  // Transaction-level model: is a transfer in flight, has its address been taken, who owns it.
  logic m_busy, m_acc;
  logic m_own0, m_own1, m_last0, m_last1;
  int   sl_cnt;

  function automatic logic [139:0] model_out(input logic k);
    logic own, ap, dp, aok, dok;
    logic [71:0] s;
    own = k ? m_own1 : m_own0;
    ap  = m_busy && !m_acc;
    dp  = m_busy && m_acc;
    s   = '0;
    if (ap) s = own ? {data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata}
                    : {inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
    aok = ap && s_addr_ok;
    dok = dp && s_data_ok;
    return {aok && !own, dok && !own, (dok && !own) ? s_rdata : 32'h0,
            aok && own, dok && own, (dok && own) ? s_rdata : 32'h0, s};
  endfunction

  task automatic advance();
    logic was_busy, was_acc;
    was_busy = m_busy;
    was_acc  = m_acc;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_own0 = 0; m_own1 = 0; m_last0 = 1; m_last1 = 1;
    end else if (!m_busy) begin
      if (inst_req || data_req) begin
        m_busy = 1;
        m_acc  = 0;
        m_own0 = (inst_req && data_req) ? !m_last0 : data_req;
        m_own1 = data_req;
      end
    end else if (!m_acc) begin
      if (s_addr_ok) begin
        m_acc = 1; m_last0 = m_own0; m_last1 = m_own1;
      end
    end else if (s_data_ok) begin
      m_busy = 0;
    end
    if (m_busy != was_busy || m_acc != was_acc) sl_cnt = 0;
    else sl_cnt++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic slave_drive(input int aw, input int dw, input logic [31:0] rd);
    s_addr_ok = 0;
    s_data_ok = 0;
    s_rdata   = $urandom;
    if (m_busy && !m_acc && sl_cnt >= aw) s_addr_ok = 1;
    if (m_busy && m_acc && sl_cnt >= dw) begin
      s_data_ok = 1;
      s_rdata   = rd;
    end
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    advance();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    inst_req = 1; data_req = 1; inst_addr = 32'h1234_5678; data_addr = 32'h8765_4321;
    rst = 1;
    advance();
    advance();
    #1;
    checks++; if (r_obs !== '0) begin errors++; $display("FAIL reset_rr got %h exp 0", r_obs); end
    checks++; if (f_obs !== '0) begin errors++; $display("FAIL reset_fp got %h exp 0", f_obs); end
    idle_inputs();
    advance();
    rst = 0;
  endtask

  task automatic test_inst_read();
    int n_aok = 0, n_dok = 0, n_other = 0, first_sreq = -1, aok_c = -1, dok_c = -1;
    logic [31:0] got_rd = 0, got_addr = 0;
    logic drop;
    idle_inputs();
    inst_req = 1; inst_size = 2; inst_addr = 32'hBFC0_0000;
    sl_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      slave_drive(2, 2, 32'h3C08_0001);
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL inst_read_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL inst_read_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if (r_s_req && first_sreq < 0) begin first_sreq = c; got_addr = r_s_addr; end
      if (r_data_addr_ok || r_data_data_ok || r_data_rdata != 0) n_other++;
      drop = r_inst_addr_ok;
      if (r_inst_addr_ok) begin n_aok++; aok_c = c; end
      if (r_inst_data_ok) begin n_dok++; dok_c = c; got_rd = r_inst_rdata; end
      advance();
      if (drop) inst_req = 0;
    end
    checks++; if (first_sreq != 1) begin errors++; $display("FAIL inst_read_sreq_cycle got %0d exp 1", first_sreq); end
    checks++; if (got_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL inst_read_saddr got %h exp bfc00000", got_addr); end
    checks++; if (n_aok != 1 || aok_c != 3) begin errors++; $display("FAIL inst_read_addr_ok got %0d@%0d exp 1@3", n_aok, aok_c); end
    checks++; if (n_dok != 1 || dok_c != 6) begin errors++; $display("FAIL inst_read_data_ok got %0d@%0d exp 1@6", n_dok, dok_c); end
    checks++; if (got_rd !== 32'h3C08_0001) begin errors++; $display("FAIL inst_read_rdata got %h exp 3c080001", got_rd); end
    checks++; if (n_other != 0) begin errors++; $display("FAIL inst_read_data_side got %0d exp 0", n_other); end
  endtask

  task automatic test_data_write();
    int n_dok = 0, n_other = 0, n_sreq = 0, bad_fields = 0;
    logic drop;
    idle_inputs();
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_0010;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    sl_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      slave_drive(1, 0, 32'h0);
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL data_write_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL data_write_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if (r_s_req) begin
        n_sreq++;
        if (r_s_wr !== 1'b1 || r_s_wstrb !== 4'hF || r_s_wdata !== 32'hDEAD_BEEF || r_s_addr !== 32'h8000_0010)
          bad_fields++;
      end
      if (r_inst_addr_ok || r_inst_data_ok || r_inst_rdata != 0) n_other++;
      if (r_data_data_ok) n_dok++;
      drop = r_data_addr_ok;
      advance();
      if (drop) data_req = 0;
    end
    checks++; if (n_sreq == 0 || bad_fields != 0) begin errors++; $display("FAIL data_write_fields got %0d bad of %0d exp 0 of >0", bad_fields, n_sreq); end
    checks++; if (n_dok != 1) begin errors++; $display("FAIL data_write_data_ok got %0d exp 1", n_dok); end
    checks++; if (n_other != 0) begin errors++; $display("FAIL data_write_inst_side got %0d exp 0", n_other); end
  endtask

  task automatic test_round_robin();
    int nacc = 0, r_id = 0, r_dd = 0, f_id = 0, f_dd = 0;
    logic [3:0] r_ord = 0, f_ord = 0;
    idle_inputs();
    pulse_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0100; inst_size = 2;
    data_req = 1; data_addr = 32'h8000_0200; data_size = 1;
    sl_cnt = 0;
    for (int c = 0; c < 80 && (nacc < 4 || m_busy); c++) begin
      slave_drive(1, 1, $urandom);
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL rr_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL rr_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if ((r_inst_addr_ok || r_data_addr_ok) && nacc < 4) begin
        r_ord[nacc] = r_data_addr_ok;
        f_ord[nacc] = f_data_addr_ok;
        nacc++;
      end
      r_id += int'(r_inst_data_ok); r_dd += int'(r_data_data_ok);
      f_id += int'(f_inst_data_ok); f_dd += int'(f_data_data_ok);
      advance();
      if (nacc == 4) begin inst_req = 0; data_req = 0; end
    end
    checks++; if (r_ord !== 4'b1010) begin errors++; $display("FAIL rr_order got %b exp 1010", r_ord); end
    checks++; if (r_id != 2 || r_dd != 2) begin errors++; $display("FAIL rr_data_ok got %0d/%0d exp 2/2", r_id, r_dd); end
    checks++; if (f_ord !== 4'b1111 || f_id != 0 || f_dd != 4) begin errors++; $display("FAIL rr_fixed_side got %b %0d/%0d exp 1111 0/4", f_ord, f_id, f_dd); end
  endtask

  task automatic test_fixed_prio();
    int nacc = 0;
    logic [3:0] f_ord = 0;
    idle_inputs();
    pulse_reset();
    inst_req = 1; inst_addr = 32'hBFC0_0300;
    data_req = 1; data_addr = 32'h8000_0400;
    sl_cnt = 0;
    for (int c = 0; c < 80 && (nacc < 4 || m_busy); c++) begin
      slave_drive(0, 1, $urandom);
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL fixed_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL fixed_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if ((f_inst_addr_ok || f_data_addr_ok) && nacc < 4) begin
        f_ord[nacc] = f_data_addr_ok;
        nacc++;
      end
      advance();
      if (nacc >= 3) data_req = 0;
      if (nacc >= 4) inst_req = 0;
    end
    checks++; if (f_ord !== 4'b0111 || nacc != 4) begin errors++; $display("FAIL fixed_order got %b n=%0d exp 0111 n=4", f_ord, nacc); end
  endtask

  task automatic test_spurious();
    int n_aok = 0, n_dok = 0, aok_c = -1, dok_c = -1, n_other = 0;
    logic drop;
    idle_inputs();
    sl_cnt = 0;
    inst_addr = 32'hBFC0_0500;
    for (int c = 0; c < 12; c++) begin
      if (c == 2) inst_req = 1;
      s_rdata = $urandom;
      if (!m_busy) begin s_addr_ok = 1; s_data_ok = 1; end
      else if (!m_acc) begin s_data_ok = 1; s_addr_ok = (sl_cnt >= 2); end
      else begin s_addr_ok = 1; s_data_ok = (sl_cnt >= 2); end
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL spurious_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL spurious_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if (r_inst_addr_ok) begin n_aok++; aok_c = c; end
      if (r_inst_data_ok) begin n_dok++; dok_c = c; end
      if (r_data_addr_ok || r_data_data_ok) n_other++;
      drop = r_inst_addr_ok;
      advance();
      if (drop) inst_req = 0;
    end
    checks++; if (n_aok != 1 || aok_c != 5) begin errors++; $display("FAIL spurious_addr_ok got %0d@%0d exp 1@5", n_aok, aok_c); end
    checks++; if (n_dok != 1 || dok_c != 8) begin errors++; $display("FAIL spurious_data_ok got %0d@%0d exp 1@8", n_dok, dok_c); end
    checks++; if (n_other != 0) begin errors++; $display("FAIL spurious_data_side got %0d exp 0", n_other); end
  endtask

  task automatic test_rst_mid();
    int n_aok = 0, n_dok = 0;
    idle_inputs();
    sl_cnt = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0600;
    for (int c = 0; c < 8; c++) begin
      rst = (c == 3);
      s_addr_ok = m_busy && !m_acc;
      s_data_ok = (c >= 4);
      s_rdata   = $urandom;
      #1;
      checks++; if (r_obs !== model_out(0)) begin errors++; $display("FAIL rst_mid_rr cyc %0d got %h exp %h", c, r_obs, model_out(0)); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL rst_mid_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      if (c == 4) begin
        checks++; if (r_obs !== '0 || f_obs !== '0) begin errors++; $display("FAIL rst_mid_zero got %h exp 0", r_obs | f_obs); end
      end
      if (r_inst_addr_ok) n_aok++;
      if (r_inst_data_ok || f_inst_data_ok) n_dok++;
      advance();
      if (c == 1) inst_req = 0;
    end
    rst = 0;
    checks++; if (n_aok != 1 || n_dok != 0) begin errors++; $display("FAIL rst_mid_pulses got %0d/%0d exp 1/0", n_aok, n_dok); end
  endtask

  task automatic test_random();
    logic [139:0] e0;
    idle_inputs();
    pulse_reset();
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!inst_req && $urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom; inst_wstrb = 4'($urandom); inst_wdata = $urandom;
      end
      if (!data_req && $urandom_range(0, 2) == 0) begin
        data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
        data_addr = $urandom; data_wstrb = 4'($urandom); data_wdata = $urandom;
      end
      s_rdata   = $urandom;
      s_addr_ok = ($urandom_range(0, 3) == 0);
      s_data_ok = ($urandom_range(0, 3) == 0);
      if (m_busy && !m_acc) s_addr_ok = (m_own0 ? data_req : inst_req) && ($urandom_range(0, 1) == 1);
      else if (m_busy && m_acc) s_data_ok = ($urandom_range(0, 2) == 0);
      #1;
      e0 = model_out(0);
      checks++; if (r_obs !== e0) begin errors++; $display("FAIL random_rr cyc %0d got %h exp %h", c, r_obs, e0); end
      checks++; if (f_obs !== model_out(1)) begin errors++; $display("FAIL random_fp cyc %0d got %h exp %h", c, f_obs, model_out(1)); end
      advance();
      if (e0[139]) begin
        inst_req = 1'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (e0[105]) begin
        data_req = 1'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    m_busy = 0; m_acc = 0; m_own0 = 0; m_own1 = 0; m_last0 = 1; m_last1 = 1;
    sl_cnt = 0;
    idle_inputs();
    test_reset();
    test_inst_read();
    test_data_write();
    test_round_robin();
    test_fixed_prio();
    test_spurious();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-master, one-slave arbiter on the SRAM-like bus. It shares one SRAM-like slave port (the AXI bridge side) between the instruction-fetch interface and the data-memory interface. It grants one master at a time, forwards that master's request, and routes the returned data_ok/rdata back to the granted master. Exactly one transaction is outstanding at any time.

## Interface
- FIXED_PRIO, default 0: 0 = round-robin when both masters request; 1 = data master always wins.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- {inst,data}_req  in  1  master request; held until that master's addr_ok
- {inst,data}_wr  in  1  1 = write, 0 = read
- {inst,data}_size  in  2  0 = byte, 1 = half, 2 = word
- {inst,data}_addr  in  32  byte address
- {inst,data}_wstrb  in  4  byte strobes (writes)
- {inst,data}_wdata  in  32  write data
- {inst,data}_addr_ok  out  1  request accepted by slave
- {inst,data}_data_ok  out  1  one-cycle completion pulse
- {inst,data}_rdata  out  32  read data; valid when data_ok
- s_req  out  1  request to slave
- s_wr, s_size, s_addr, s_wstrb, s_wdata  out  1/2/32/4/32  forwarded from granted master
- s_addr_ok  in  1  slave accepted request (handshake = s_req & s_addr_ok)
- s_data_ok  in  1  slave completion pulse
- s_rdata  in  32  slave read data

## Operation
- States: IDLE, ADDR, DATA. Registers: state, grant (0 = inst, 1 = data), last_grant.
- IDLE: all s_* outputs are 0. If any *_req = 1, latch grant and go to ADDR.
  - Only one master requesting: that master is granted.
  - Both requesting, FIXED_PRIO = 1: data is granted.
  - Both requesting, FIXED_PRIO = 0: the master not equal to last_grant is granted.
- ADDR: s_req and all s_* fields come combinationally from the granted master's inputs. Granted *_addr_ok = s_addr_ok. Non-granted addr_ok = 0. On s_addr_ok = 1, go to DATA and set last_grant = grant.
- DATA: s_req = 0. Granted *_data_ok = s_data_ok. Granted *_rdata = s_rdata. On s_data_ok = 1, go to IDLE.
- Non-granted *_data_ok and *_rdata are always 0. Granted *_rdata is 0 when s_data_ok = 0.
- s_data_ok in IDLE or ADDR is ignored: no master pulse is generated.
- s_addr_ok in IDLE or DATA is ignored.
- A master dropping req while granted in ADDR is a protocol violation. It is not checked; the arbiter stays in ADDR.
- Writes and reads are sequenced identically. The slave returns data_ok for writes too.

## Timing
- Reset: state = IDLE, grant = 0, last_grant = 1 (first tie goes to inst in round-robin). Every output is 0.
- rst asserted mid-transaction: next cycle is IDLE, the transaction is abandoned, and no data_ok is forwarded. The slave shares the same rst.
- Request sampled in IDLE at cycle N: s_req = 1 at N+1. Earliest master addr_ok is at N+1.
- s_addr_ok at cycle M: DATA from M+1. Earliest data_ok is at M+1; it passes through combinationally in the same cycle.
- data_ok at cycle K: IDLE at K+1, next arbitration at K+1, next s_req at K+2. Minimum turnaround between transactions is 2 idle-side cycles.
- s_addr_ok and s_data_ok are never both honoured in one cycle, because only one state consumes each.
- No combinational path from s_addr_ok/s_data_ok to s_req.

## Test plan
- Single inst read: inst_req = 1, addr 0xBFC0_0000, size 2; slave addr_ok after 2 cycles, data_ok 3 cycles later with rdata 0x3C08_0001 -> s_addr = 0xBFC0_0000, one inst_addr_ok pulse, one inst_data_ok pulse with inst_rdata = 0x3C08_0001, data_* outputs stay 0.
- Data write: data_req = 1, wr = 1, addr 0x8000_0010, wstrb 0xF, wdata 0xDEAD_BEEF -> s_wr = 1, s_wstrb = 0xF, s_wdata = 0xDEAD_BEEF; data_data_ok pulses once on s_data_ok.
- Simultaneous requests, FIXED_PRIO = 0, both held for 4 transactions -> grant order after reset is inst, data, inst, data; each master gets exactly 2 addr_ok and 2 data_ok.
- Simultaneous requests, FIXED_PRIO = 1 -> data granted every time while data_req stays high; inst granted only in the first IDLE where data_req = 0.
- Spurious s_data_ok in ADDR, and s_addr_ok in DATA -> no master pulses, no state change beyond the specified transitions.
- rst pulsed in DATA before s_data_ok -> next cycle all outputs 0 and state IDLE; a later s_data_ok produces no master data_ok.
